// File: rtl/slow_clock_generator_if.sv
// rtl/slow_clock_generator_if.sv - enable request, slow clock and event strobe bundle
interface slow_clock_generator_if;
    logic enable_clk;
    logic new_clk;
    logic rising_edge;
    logic falling_edge;
    logic middle_of_high_level;
    logic middle_of_low_level;
    logic running;

    // Consumer side: requests the clock and receives the clock and strobes
    modport master (
        output enable_clk,
        input  new_clk,
        input  rising_edge,
        input  falling_edge,
        input  middle_of_high_level,
        input  middle_of_low_level,
        input  running
    );

    // Generator side
    modport slave (
        input  enable_clk,
        output new_clk,
        output rising_edge,
        output falling_edge,
        output middle_of_high_level,
        output middle_of_low_level,
        output running
    );
endinterface

// File: rtl/slow_clock_generator.sv
// rtl/slow_clock_generator.sv - power-of-two slow clock divider with edge/midpoint strobes (option: SLOW_CLK_MIDPOINT_EN)
module slow_clock_generator #(
    parameter int COUNTER_BITS = 10,
    parameter int COUNTER_INC  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    slow_clock_generator_if.slave bus
);
    localparam int N = COUNTER_BITS;
    localparam logic [N-1:0] INC = N'(COUNTER_INC);

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUNNING  = 2'd1,
        DRAINING = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   counter;
    logic [N-1:0]   counter_next;
    logic [N-1:0]   counter_inc;
    logic           new_clk_q;
    logic           rising_edge_q;
    logic           falling_edge_q;

    assign counter_inc = counter + INC;

    // Next state and next counter; a drain ends only at the high-to-low wrap so every period is full
    always_comb begin
        state_next   = state;
        counter_next = counter;
        case (state)
            STOPPED: begin
                counter_next = '0;
                if (bus.enable_clk) begin
                    counter_next = INC;
                    state_next   = RUNNING;
                end
            end
            RUNNING: begin
                counter_next = counter_inc;
                if (!bus.enable_clk) begin
                    state_next = DRAINING;
                end
            end
            DRAINING: begin
                counter_next = counter_inc;
                if (bus.enable_clk) begin
                    state_next = RUNNING;
                end else if (!counter_inc[N-1] && new_clk_q) begin
                    counter_next = '0;
                    state_next   = STOPPED;
                end
            end
            default: begin
                counter_next = '0;
                state_next   = STOPPED;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STOPPED;
        end else begin
            state <= state_next;
        end
    end

    // Counter, registered slow clock and its edge strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            counter        <= '0;
            new_clk_q      <= 1'b0;
            rising_edge_q  <= 1'b0;
            falling_edge_q <= 1'b0;
        end else begin
            counter        <= counter_next;
            new_clk_q      <= counter[N-1];
            rising_edge_q  <= counter[N-1] & ~new_clk_q;
            falling_edge_q <= ~counter[N-1] & new_clk_q;
        end
    end

`ifdef SLOW_CLK_MIDPOINT_EN
    logic q_bit;
    logic mid_high_q;
    logic mid_low_q;

    // Rising edge of the second-highest counter bit marks the middle of each half period
    always_ff @(posedge clk) begin
        if (reset) begin
            q_bit      <= 1'b0;
            mid_high_q <= 1'b0;
            mid_low_q  <= 1'b0;
        end else begin
            q_bit      <= counter[N-2];
            mid_high_q <= counter[N-2] & ~q_bit & counter[N-1];
            mid_low_q  <= counter[N-2] & ~q_bit & ~counter[N-1];
        end
    end

    assign bus.middle_of_high_level = mid_high_q;
    assign bus.middle_of_low_level  = mid_low_q;
`else
    assign bus.middle_of_high_level = 1'b0;
    assign bus.middle_of_low_level  = 1'b0;
`endif

    assign bus.new_clk      = new_clk_q;
    assign bus.rising_edge  = rising_edge_q;
    assign bus.falling_edge = falling_edge_q;
    assign bus.running      = (state != STOPPED);
endmodule

// File: tb/tb_slow_clock_generator.sv
// tb/tb_slow_clock_generator.sv - directed self-checking bench for slow_clock_generator
module tb_slow_clock_generator;
    logic clk;
    logic reset;
    logic enable_clk;
    int   n_tests;
    int   n_fail;

    slow_clock_generator_if if_a ();
    slow_clock_generator_if if_b ();

    assign if_a.enable_clk = enable_clk;
    assign if_b.enable_clk = enable_clk;

    // Both instances have P = 16 and must produce identical timing
    slow_clock_generator #(.COUNTER_BITS(4), .COUNTER_INC(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    slow_clock_generator #(.COUNTER_BITS(6), .COUNTER_INC(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic e_clk, input logic e_rise,
                           input logic e_fall, input logic e_mlow, input logic e_mhigh,
                           input logic e_run);
        logic ml;
        logic mh;
`ifdef SLOW_CLK_MIDPOINT_EN
        ml = e_mlow;
        mh = e_mhigh;
`else
        ml = 1'b0;
        mh = 1'b0;
`endif
        chk({tag, "/a new_clk"},  k, if_a.new_clk,              e_clk);
        chk({tag, "/a rise"},     k, if_a.rising_edge,          e_rise);
        chk({tag, "/a fall"},     k, if_a.falling_edge,         e_fall);
        chk({tag, "/a mid_low"},  k, if_a.middle_of_low_level,  ml);
        chk({tag, "/a mid_high"}, k, if_a.middle_of_high_level, mh);
        chk({tag, "/a running"},  k, if_a.running,              e_run);
        chk({tag, "/b new_clk"},  k, if_b.new_clk,              e_clk);
        chk({tag, "/b rise"},     k, if_b.rising_edge,          e_rise);
        chk({tag, "/b fall"},     k, if_b.falling_edge,         e_fall);
        chk({tag, "/b mid_low"},  k, if_b.middle_of_low_level,  ml);
        chk({tag, "/b mid_high"}, k, if_b.middle_of_high_level, mh);
        chk({tag, "/b running"},  k, if_b.running,              e_run);
    endtask

    // Free-running expectation k cycles after the enabling edge E (P = 16)
    task automatic chk_run(input string tag, input int k);
        int ph;
        ph = k % 16;
        chk_all(tag, k, (ph >= 8), (ph == 8), (ph == 0), (ph == 4), (ph == 12), 1'b1);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable_clk = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        enable_clk = 1'b0;

        // Reset state: everything low, stays low while stopped
        step();
        step();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        step();
        chk_all("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Free run: rise at E+8, fall at E+16, rise at E+24
        enable_clk = 1'b1;
        step();
        chk_all("run", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_run("run", k);
        end

        // Stop requested in the low half: full high half, last fall at E+16, running low after E+15
        do_reset();
        enable_clk = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            step();
            chk_all("drain", k, (k >= 8 && k <= 15), (k == 8), (k == 16), (k == 4), (k == 12), (k <= 14));
            if (k == 2) enable_clk = 1'b0;
        end

        // Brief stop request in the high half is cancelled: period unchanged
        do_reset();
        enable_clk = 1'b1;
        step();
        for (int k = 1; k <= 32; k++) begin
            step();
            chk_run("cancel", k);
            if (k == 10) enable_clk = 1'b0;
            if (k == 12) enable_clk = 1'b1;
        end

        // Reset while new_clk is high: no falling edge, then a clean restart
        do_reset();
        enable_clk = 1'b1;
        step();
        for (int k = 1; k <= 11; k++) begin
            step();
            chk_run("pre_rst", k);
        end
        reset      = 1'b1;
        enable_clk = 1'b0;
        step();
        chk_all("mid_rst", 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int k = 13; k <= 20; k++) begin
            step();
            chk_all("post_rst", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        enable_clk = 1'b1;
        step();
        for (int k = 1; k <= 24; k++) begin
            step();
            chk_run("restart", k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
